// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for an 8-bit Fibonacci LFSR stream. It self-synchronises
//   to the incoming words. Once locked, it flags every valid sample that deviates
//   from the expected sequence and keeps a saturating error count.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous active-low reset
//   data_in     received LFSR word
//   data_valid  data_in carries a sample this cycle
//   clear_cnt   synchronous clear of err_count (wins over a same-cycle increment)
//   locked      checker is synchronised to the stream
//   err_pulse   one-cycle flag: the last valid sample mismatched while locked
//   err_count   saturating count of mismatches seen while locked
module lfsr_checker #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
   parameter int               LOCK_COUNT = 4,
   parameter int               LOSS_COUNT = 3,
   parameter int               CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [0:0] ACQ    = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
   localparam logic [3:0]       LOSS_C  = 4'(LOSS_COUNT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [0:0]       state;
   logic             have_prev;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] expected;
   logic [3:0]       match_cnt;
   logic [3:0]       miss_cnt;

   function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   assign locked = (state == LOCKED);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ACQ;
         have_prev <= 1'b0;
         prev      <= '0;
         expected  <= '0;
         match_cnt <= 4'd0;
         miss_cnt  <= 4'd0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         // The pulse lasts only for the cycle that follows the offending sample.
         err_pulse <= 1'b0;
         if (clear_cnt)
            err_count <= '0;

         if (data_valid) begin
            case (state)
               ACQ: begin
                  if (data_in == '0) begin
                     // All-zero is the LFSR lock-up state and never part of a
                     // valid sequence, so restart the acquisition from scratch.
                     match_cnt <= 4'd0;
                     have_prev <= 1'b0;
                  end else begin
                     prev      <= data_in;
                     have_prev <= 1'b1;
                     if (have_prev && data_in == lfsr_next(prev)) begin
                        if (match_cnt + 4'd1 == LOCK_C) begin
                           state     <= LOCKED;
                           expected  <= lfsr_next(data_in);
                           miss_cnt  <= 4'd0;
                           match_cnt <= 4'd0;
                        end else begin
                           match_cnt <= match_cnt + 4'd1;
                        end
                     end else begin
                        match_cnt <= 4'd0;
                     end
                  end
               end
               default: begin
                  // The expected word free-runs, so one corrupted word costs
                  // exactly one error. It is never re-seeded from bad data.
                  expected <= lfsr_next(expected);
                  if (data_in == expected) begin
                     miss_cnt <= 4'd0;
                  end else begin
                     err_pulse <= 1'b1;
                     if (!clear_cnt && err_count != CNT_MAX)
                        err_count <= err_count + 1'b1;
                     if (miss_cnt + 4'd1 == LOSS_C) begin
                        state     <= ACQ;
                        match_cnt <= 4'd0;
                        have_prev <= 1'b0;
                        miss_cnt  <= 4'd0;
                     end else begin
                        miss_cnt <= miss_cnt + 4'd1;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker. Two instances share one stimulus stream: the default
// build (a) and a small-counter, high-loss-threshold build (b) for saturation.
// Each step pushes the expected response, and a monitor compares it one edge later.
module tb_lfsr_checker;

   logic       clk;
   logic       reset;
   logic [7:0] data_in;
   logic       data_valid;
   logic       clear_cnt;

   logic        a_locked, a_pulse;
   logic [15:0] a_count;
   logic        b_locked, b_pulse;
   logic [3:0]  b_count;

   lfsr_checker dut_a (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .clear_cnt(clear_cnt), .locked(a_locked), .err_pulse(a_pulse), .err_count(a_count)
   );

   lfsr_checker #(.LOSS_COUNT(15), .CNT_W(4)) dut_b (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .clear_cnt(clear_cnt), .locked(b_locked), .err_pulse(b_pulse), .err_count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit    sel;
      int    lk;
      int    pl;
      int    cnt;
      string tag;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [7:0] e;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] nxt(input logic [7:0] s);
      return {s[6:0], ^(s & 8'hB8)};
   endfunction

   // The monitor compares the response to each sampled step 1 time unit after the edge.
   always @(posedge clk) begin
      exp_t it;
      #1;
      if (sbq.size() > 0) begin
         it = sbq.pop_front();
         if (it.sel) begin
            chk({it.tag, ".b.locked"}, int'(b_locked), it.lk);
            chk({it.tag, ".b.err_pulse"}, int'(b_pulse), it.pl);
            chk({it.tag, ".b.err_count"}, int'(b_count), it.cnt);
         end else begin
            chk({it.tag, ".a.locked"}, int'(a_locked), it.lk);
            chk({it.tag, ".a.err_pulse"}, int'(a_pulse), it.pl);
            chk({it.tag, ".a.err_count"}, int'(a_count), it.cnt);
         end
      end
   end

   task automatic step(input string tag, input bit rst_n, input logic [7:0] d, input bit v,
                       input bit c, input bit s, input int lk, input int pl, input int cnt);
      exp_t it;
      @(negedge clk);
      reset = rst_n; data_in = d; data_valid = v; clear_cnt = c;
      it.sel = s; it.lk = lk; it.pl = pl; it.cnt = cnt; it.tag = tag;
      sbq.push_back(it);
   endtask

   // Sends the correct next word while locked.
   task automatic good(input string tag, input bit s, input int cnt);
      step(tag, 1'b1, e, 1'b1, 1'b0, s, 1, 0, cnt);
      e = nxt(e);
   endtask

   // Sends a wrong word while locked. The expected word still advances.
   task automatic bad(input string tag, input bit s, input int lk, input int cnt, input bit c);
      step(tag, 1'b1, ~e, 1'b1, c, s, lk, 1, cnt);
      e = nxt(e);
   endtask

   // Sends five consecutive words from seed w. Lock is expected after the fifth.
   task automatic relock(input string tag, input logic [7:0] w, input bit s, input int cnt);
      logic [7:0] x;
      x = w;
      for (int i = 0; i < 5; i++) begin
         step(tag, 1'b1, x, 1'b1, 1'b0, s, (i == 4) ? 1 : 0, 0, cnt);
         x = nxt(x);
      end
      e = x;
   endtask

   initial begin
      reset = 1'b0; data_in = 8'h00; data_valid = 1'b0; clear_cnt = 1'b0;

      // Reset state.
      step("rst0", 1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0);
      step("rst1", 1'b0, 8'h55, 1'b1, 1'b0, 0, 0, 0, 0);

      // Lock acquisition.
      step("acq01", 1'b1, 8'h01, 1'b1, 1'b0, 0, 0, 0, 0);
      step("acq02", 1'b1, 8'h02, 1'b1, 1'b0, 0, 0, 0, 0);
      step("acq04", 1'b1, 8'h04, 1'b1, 1'b0, 0, 0, 0, 0);
      step("acq08", 1'b1, 8'h08, 1'b1, 1'b0, 0, 0, 0, 0);
      step("acq11", 1'b1, 8'h11, 1'b1, 1'b0, 0, 1, 0, 0);

      // Single error.
      step("err23", 1'b1, 8'h23, 1'b1, 1'b0, 0, 1, 0, 0);
      step("err46", 1'b1, 8'h46, 1'b1, 1'b0, 0, 1, 1, 1);
      step("err8E", 1'b1, 8'h8E, 1'b1, 1'b0, 0, 1, 0, 1);
      e = 8'h1C;

      // Valid gaps. The expected word must not advance during a gap.
      for (int i = 0; i < 4; i++) begin
         step("gap", 1'b1, 8'hFF, 1'b0, 1'b0, 0, 1, 0, 1);
         good("gapok", 0, 1);
      end

      // Loss of lock through three zero words, then relock.
      step("loss0", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1, 1, 2);
      step("loss1", 1'b1, 8'h00, 1'b1, 1'b0, 0, 1, 1, 3);
      step("loss2", 1'b1, 8'h00, 1'b1, 1'b0, 0, 0, 1, 4);
      step("acqidle", 1'b1, 8'hFF, 1'b0, 1'b0, 0, 0, 0, 4);
      relock("relock", 8'h5A, 0, 4);
      good("relockok", 0, 4);

      // Reset mid-lock with five errors counted.
      bad("to5", 0, 1, 5, 1'b0);
      good("at5", 0, 5);
      step("midrst", 1'b0, e, 1'b1, 1'b0, 0, 0, 0, 0);
      step("postrst", 1'b1, 8'hFF, 1'b0, 1'b0, 0, 0, 0, 0);

      // A clear together with a mismatch: the clear wins, and the pulse still fires.
      relock("relock2", 8'hC3, 0, 0);
      bad("pre_clr", 0, 1, 1, 1'b0);
      bad("clr_hit", 0, 1, 0, 1'b1);
      good("post_clr", 0, 0);

      // Saturation on the 4-bit counter build.
      step("b_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1, 0, 0, 0);
      relock("b_lock", 8'h37, 1, 0);
      for (int i = 0; i < 20; i++) begin
         bad("sat_err", 1, 1, (i + 1 > 15) ? 15 : i + 1, 1'b0);
         good("sat_ok", 1, (i + 1 > 15) ? 15 : i + 1);
      end

      repeat (3) @(negedge clk);
      chk("sb_drain", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the 8-bit LFSR pattern generator. It consumes the generator's 8-bit parallel output stream and self-synchronises to it.
- Once locked, it flags every sample that deviates from the expected LFSR sequence and keeps a saturating error count.
- Used in loopback/BIST paths to verify that an LFSR stream survived transport intact.

Parameters:
- WIDTH, 8: LFSR and data width.
- TAPS, 8'hB8: feedback mask for x^8+x^6+x^5+x^4+1. next(s) = {s[WIDTH-2:0], ^(s & TAPS)}.
- LOCK_COUNT, 4: consecutive correct transitions required to declare lock (1..15).
- LOSS_COUNT, 3: consecutive mismatches while locked that drop lock (1..15).
- CNT_W, 16: error counter width.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- data_in  input  WIDTH  received LFSR word.
- data_valid  input  1  data_in is a valid sample this cycle.
- clear_cnt  input  1  synchronous clear of err_count.
- locked  output  1  checker is synchronised to the stream.
- err_pulse  output  1  one-cycle flag: the last valid sample mismatched while locked.
- err_count  output  CNT_W  saturating count of mismatches while locked.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to ACQ; have_prev=0; match_cnt=0; miss_cnt=0.
  - Outputs: locked=0, err_pulse=0, err_count=0. Expected and prev registers are 0.
  - Reset overrides every other input, including mid-lock.
- data_valid==0: all state and counters hold. err_pulse=0 (the pulse is never stretched).
- All outputs are registered. The response to a sample appears in the cycle after it is sampled.
- State ACQ (locked=0), on each valid sample:
  - If data_in==0: treat as illegal. match_cnt=0, have_prev=0.
  - Else if have_prev && data_in==next(prev): match_cnt += 1.
  - Else: match_cnt=0.
  - In all non-zero cases, prev<=data_in and have_prev=1.
  - When match_cnt reaches LOCK_COUNT: go to LOCKED, locked=1, expected<=next(data_in), miss_cnt=0.
  - err_pulse is always 0 in ACQ and err_count does not change.
- State LOCKED (locked=1), on each valid sample:
  - The expected register free-runs: expected<=next(expected) whether or not the sample matched. A single corrupted word therefore causes exactly one error, with no propagation.
  - Match (data_in==expected): miss_cnt=0, err_pulse=0.
  - Mismatch: err_pulse=1, err_count+=1 (saturates at 2^CNT_W-1), miss_cnt+=1.
  - When miss_cnt reaches LOSS_COUNT: go to ACQ next cycle. locked=0, match_cnt=0, have_prev=0. The triggering sample is still counted as an error.
- clear_cnt: err_count<=0. Clear has priority over a simultaneous increment. err_pulse still asserts for that mismatch.
- An all-zero word while locked is an ordinary mismatch.
- Lock is lost only through LOSS_COUNT consecutive mismatches. Isolated errors never drop lock.
- Width rules:
  - match_cnt and miss_cnt are 4 bits.
  - err_count holds at all-ones; it never wraps.

Test Plan:
1. Lock acquisition:
   - Stimulus: after reset, apply valid words 01,02,04,08,11, back to back.
   - Required: locked=0 through sample 08. locked=1 in the cycle after 11 is sampled. err_count=0.
2. Single error:
   - Stimulus: while locked, expected words are 23,47,8E. Apply 23,46,8E.
   - Required: err_pulse=1 for exactly one cycle (after 46). err_count=1. locked stays 1. 8E matches with no further errors.
3. Loss of lock:
   - Stimulus: while locked, apply 00 three times.
   - Required: err_pulse high for 3 cycles. err_count increments by 3. locked=0 after the third. Re-feeding a valid run of 5 consecutive LFSR words relocks.
4. Valid gaps:
   - Stimulus: interleave data_valid=0 cycles (data_in=FF) within a locked correct stream.
   - Required: no err_pulse. locked stays 1. Expected does not advance during gaps.
5. Reset mid-lock and clear:
   - Stimulus: with err_count=5, pulse reset=0 for one cycle.
   - Required: locked=0 and err_count=0 next cycle.
   - Stimulus: separately, assert clear_cnt together with a mismatch.
   - Required: err_count=0 and err_pulse=1.
6. Saturation:
   - Stimulus: with CNT_W=4 and LOSS_COUNT=15, inject 20 errors, each followed by a matching word.
   - Required: err_count holds at 15. locked stays 1.
